misr_sig_checker: RTL
=====================

# misr_sig_checker

Bus-master sequencer that runs a MISR self-test through the MISR peripheral's memory-mapped register interface. On a start pulse it:
- programs CTRL and COEFFICIENTS;
- polls DONE;
- reads SIGNATURE and compares it against a golden value;
- leaves the MISR disabled and reports pass, fail or timeout.

It sits directly downstream of the MISR peripheral and drives its re/we/addr/data port, standing in for the core's load/store path during test.

## Interface
Parameters:
- NBIT_DATA, 64, data/register width
- NBIT_ADDR, 64, bus address width
- START_ADDR, 2**25, MISR peripheral base address
- POLL_GAP, 4, idle cycles between consecutive DONE reads (≥1)
- TIMEOUT, 1024, cycle budget from run-enable until DONE must be seen (≥8)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- start_i  in  1  start request; sampled only in IDLE
- coeff_i  in  NBIT_DATA  polynomial coefficients; captured at start
- golden_i  in  NBIT_DATA  expected signature; captured at start
- busy_o  out  1  high from the cycle after accepted start until done_o rises
- done_o  out  1  sticky completion flag; cleared by next accepted start
- pass_o  out  1  signature equals golden; valid while done_o
- timeout_o  out  1  DONE never seen within TIMEOUT; valid while done_o
- signature_o  out  NBIT_DATA  signature read back; 0 on timeout
- re_o  out  1  bus read strobe
- we_o  out  1  bus write strobe
- addr_o  out  NBIT_ADDR  bus address
- wdata_o  out  NBIT_DATA  bus write data
- rdata_i  in  NBIT_DATA  bus read data, valid one cycle after the re_o cycle

## Operation
- Register map, byte offsets from START_ADDR:
  - CTRL at 0: bit0 enable, bit1 clear.
  - COEFFICIENTS at 8.
  - SIGNATURE at 16.
  - DONE at 24: bit0 is the done flag.
- All bus outputs are registered. Exactly one strobe is high per bus cycle. addr_o and wdata_o are 0 when no strobe is high.
- FSM states and transitions:
  - IDLE: on start_i, capture coeff_i and golden_i, clear done/pass/timeout/signature, go to WR_CLR.
  - WR_CLR: write CTRL = 0b11 (enable + clear).
  - WR_COEF: write COEFFICIENTS = captured coeff.
  - WR_RUN: write CTRL = 0b01 (enable). Timeout counter is cleared to 0.
  - POLL_RD: read DONE.
  - POLL_WAIT: sample rdata_i[0].
    - If 1, go to SIG_RD.
    - Else if counter ≥ TIMEOUT, set timeout and go to WR_STOP.
    - Else go to GAP.
  - GAP: idle POLL_GAP cycles, then POLL_RD.
  - SIG_RD: read SIGNATURE.
  - SIG_WAIT: register rdata_i into signature_o; set pass = (rdata_i == golden).
  - WR_STOP: write CTRL = 0.
  - FIN: set done_o, go to IDLE.
- The timeout counter increments every cycle in POLL_RD, POLL_WAIT and GAP. It saturates at TIMEOUT.
- DONE bit seen in the same POLL_WAIT where the counter reaches TIMEOUT: DONE wins, normal signature read.
- start_i is ignored outside IDLE. A start in the same cycle FIN returns to IDLE is ignored; start is accepted in IDLE only.
- Comparison is full-width equality. Bits of rdata_i other than bit0 are ignored during DONE polling.

## Timing
- Reset values: all outputs 0, FSM in IDLE, captured registers 0.
- rst_i high at any edge, including mid-poll or mid-write, forces IDLE with all strobes low from the next cycle. No CTRL=0 stop write is issued.
- Sequence for start_i high at edge k, with DONE seen on the first poll:
  - WR_CLR at k+1, WR_COEF at k+2, WR_RUN at k+3.
  - DONE read at k+4, sampled at k+5.
  - SIGNATURE read at k+6, sampled at k+7.
  - stop write at k+8.
  - done_o/pass_o high from k+9; busy_o falls at k+9.
- Each additional poll adds POLL_GAP+2 cycles.
- pass_o, timeout_o and signature_o are stable from the cycle done_o rises until the next accepted start.

## Structure
- Shared package misr_pkg holds:
  - register offsets (CTRL 0, COEFFICIENTS 8, SIGNATURE 16, DONE 24);
  - CTRL bit indices (enable 0, clear 1) and DONE bit index 0;
  - the FSM state enum misr_chk_state_e.
- Single module. No sub-module; the poll-gap counter and timeout counter are inline.

## Test plan
- Slave model returns DONE=0, 0, 1 on successive polls and SIGNATURE 0xDEADBEEF01234567; golden_i identical. Required:
  - writes CTRL=3, COEF=coeff_i, CTRL=1 at START_ADDR+0/+8/+0;
  - three DONE reads at +24, spaced POLL_GAP+2 cycles apart;
  - one read at +16, then CTRL=0;
  - done_o=1, pass_o=1, timeout_o=0.
- Same stimulus with golden_i 0xDEADBEEF01234566 -> pass_o=0, timeout_o=0, signature_o=0xDEADBEEF01234567.
- TIMEOUT=16, slave DONE stuck at 0 -> no SIGNATURE read, CTRL=0 written, done_o=1, timeout_o=1, pass_o=0, signature_o=0.
- DONE=1 first poll -> done_o rises exactly 9 cycles after the start edge. start_i pulsed again at k+5 -> ignored, no second sequence.
- rst_i asserted for one cycle during GAP -> next cycle: re_o=we_o=0, busy_o=0, done_o=0. A fresh start afterwards completes normally with pass_o=1.

Source files
------------

// File: rtl/misr_pkg.sv
// Shared definitions for the MISR self-test sequencer: register map,
// control/status bit positions and the sequencer state encoding.
package misr_pkg;

  // Byte offsets of the MISR peripheral registers from its base address
  localparam logic [7:0] REG_CTRL = 8'd0;
  localparam logic [7:0] REG_COEF = 8'd8;
  localparam logic [7:0] REG_SIG  = 8'd16;
  localparam logic [7:0] REG_DONE = 8'd24;

  // CTRL register fields
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  // DONE register field
  localparam int DONE_BIT = 0;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_CLR    = 4'd1,
    S_WR_COEF   = 4'd2,
    S_WR_RUN    = 4'd3,
    S_POLL_RD   = 4'd4,
    S_POLL_WAIT = 4'd5,
    S_GAP       = 4'd6,
    S_SIG_RD    = 4'd7,
    S_SIG_WAIT  = 4'd8,
    S_WR_STOP   = 4'd9,
    S_FIN       = 4'd10
  } misr_chk_state_e;

endpackage

// File: rtl/misr_sig_checker.sv
// Bus-master sequencer that runs one MISR self-test: program the MISR,
// poll its DONE flag with a bounded budget, read the signature, compare
// it against a golden value and leave the MISR disabled.
module misr_sig_checker
  import misr_pkg::*;
#(
  parameter int                   NBIT_DATA  = 64,
  parameter int                   NBIT_ADDR  = 64,
  parameter logic [NBIT_ADDR-1:0] START_ADDR = NBIT_ADDR'(2**25),
  parameter int                   POLL_GAP   = 4,
  parameter int                   TIMEOUT    = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [NBIT_DATA-1:0] coeff_i,
  input  logic [NBIT_DATA-1:0] golden_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [NBIT_DATA-1:0] signature_o,
  output logic                 re_o,
  output logic                 we_o,
  output logic [NBIT_ADDR-1:0] addr_o,
  output logic [NBIT_DATA-1:0] wdata_o,
  input  logic [NBIT_DATA-1:0] rdata_i
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  misr_chk_state_e        state, state_n;
  logic [NBIT_DATA-1:0]   coeff_q, golden_q;
  logic [TW-1:0]          to_cnt;
  logic [GW-1:0]          gap_cnt;
  logic                   to_expired;
  logic                   re_n, we_n;
  logic [NBIT_ADDR-1:0]   addr_n;
  logic [NBIT_DATA-1:0]   wdata_n;

  assign to_expired = (to_cnt >= TW'(TIMEOUT));

  function automatic logic [NBIT_ADDR-1:0] reg_addr(input logic [7:0] off);
    return START_ADDR + NBIT_ADDR'(off);
  endfunction

  // Next-state logic; a DONE flag seen on the final budgeted poll still wins
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (start_i) state_n = S_WR_CLR;
      S_WR_CLR:    state_n = S_WR_COEF;
      S_WR_COEF:   state_n = S_WR_RUN;
      S_WR_RUN:    state_n = S_POLL_RD;
      S_POLL_RD:   state_n = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (rdata_i[DONE_BIT])  state_n = S_SIG_RD;
        else if (to_expired)    state_n = S_WR_STOP;
        else                    state_n = S_GAP;
      end
      S_GAP:       if (gap_cnt == GW'(POLL_GAP - 1)) state_n = S_POLL_RD;
      S_SIG_RD:    state_n = S_SIG_WAIT;
      S_SIG_WAIT:  state_n = S_WR_STOP;
      S_WR_STOP:   state_n = S_FIN;
      S_FIN:       state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // Bus cycle for the upcoming state, so the registered strobes line up with it
  always_comb begin
    re_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = '0;
    wdata_n = '0;
    case (state_n)
      S_WR_CLR: begin
        we_n                  = 1'b1;
        addr_n                = reg_addr(REG_CTRL);
        wdata_n[CTRL_EN_BIT]  = 1'b1;
        wdata_n[CTRL_CLR_BIT] = 1'b1;
      end
      S_WR_COEF: begin
        we_n    = 1'b1;
        addr_n  = reg_addr(REG_COEF);
        wdata_n = coeff_q;
      end
      S_WR_RUN: begin
        we_n                 = 1'b1;
        addr_n               = reg_addr(REG_CTRL);
        wdata_n[CTRL_EN_BIT] = 1'b1;
      end
      S_POLL_RD: begin
        re_n   = 1'b1;
        addr_n = reg_addr(REG_DONE);
      end
      S_SIG_RD: begin
        re_n   = 1'b1;
        addr_n = reg_addr(REG_SIG);
      end
      S_WR_STOP: begin
        we_n   = 1'b1;
        addr_n = reg_addr(REG_CTRL);
      end
      default: ;
    endcase
  end

  // State and registered bus outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      re_o    <= 1'b0;
      we_o    <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
      busy_o  <= 1'b0;
    end else begin
      state   <= state_n;
      re_o    <= re_n;
      we_o    <= we_n;
      addr_o  <= addr_n;
      wdata_o <= wdata_n;
      busy_o  <= (state_n != S_IDLE) && (state_n != S_FIN);
    end
  end

  // Poll-gap counter (restarts on every GAP entry) and saturating timeout budget
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      gap_cnt <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
      if (state == S_WR_RUN)
        to_cnt <= '0;
      else if ((state == S_POLL_RD || state == S_POLL_WAIT || state == S_GAP) && !to_expired)
        to_cnt <= to_cnt + TW'(1);
    end
  end

  // Captured operands and sticky result flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      coeff_q     <= '0;
      golden_q    <= '0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      timeout_o   <= 1'b0;
      signature_o <= '0;
    end else begin
      if (state == S_IDLE && start_i) begin
        coeff_q     <= coeff_i;
        golden_q    <= golden_i;
        done_o      <= 1'b0;
        pass_o      <= 1'b0;
        timeout_o   <= 1'b0;
        signature_o <= '0;
      end
      if (state == S_POLL_WAIT && !rdata_i[DONE_BIT] && to_expired)
        timeout_o <= 1'b1;
      if (state == S_SIG_WAIT) begin
        signature_o <= rdata_i;
        pass_o      <= (rdata_i == golden_q);
      end
      if (state_n == S_FIN)
        done_o <= 1'b1;
    end
  end

endmodule
